pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage core. Drives hold/flush of PC, if_id and id_ex.
//  Sources: EX-stage jump/branch redirect, memory wait requests and load-use hazards.
//  Sits beside the pipeline regs; their dff_set instances load set_data (INST_NOP / 0) on flush.
//  Also holds the data for the PC on hold; redirects and wait cycles are counted for perf/debug.
// PARAMETERS
//  ADDR_W    32   instruction address width
//  REG_AW    5    register-file index width
//  CNT_W     16   width of the stall-cycle counter (saturating)
//  MAX_WAIT  255  consecutive mem_busy cycles before err_timeout_o sets
// PORTS
//  clk             in   1       core clock
//  rst_n           in   1       synchronous, active-low reset
//  jump_en_i       in   1       EX requests redirect this cycle
//  jump_addr_i     in   ADDR_W  redirect target
//  ex_is_load_i    in   1       instruction in EX is a load
//  ex_rd_i         in   REG_AW  destination reg of EX instruction
//  id_rs1_i        in   REG_AW  ID source 1 index
//  id_rs2_i        in   REG_AW  ID source 2 index
//  id_rs1_used_i   in   1       ID instruction reads rs1
//  id_rs2_used_i   in   1       ID instruction reads rs2
//  mem_busy_i      in   1       inst/data memory not ready; freeze pipe
//  hold_pc_o       out  1       PC keeps value
//  hold_if_id_o    out  1       if_id keeps value
//  flush_if_id_o   out  1       if_id loads INST_NOP / addr 0
//  flush_id_ex_o   out  1       id_ex loads bubble
//  pc_sel_o        out  1       PC takes redirect_addr_o next edge
//  redirect_addr_o out  ADDR_W  redirect target
//  stall_cnt_o     out  CNT_W   total stall cycles, saturates at all-ones
//  err_timeout_o   out  1       sticky: mem_busy_i exceeded MAX_WAIT cycles
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=RUN, pend_vld=0, pend_addr=0, wait_cnt=0, stall_cnt_o=0, err_timeout_o=0.
//    While rst_n=0, all combinational outputs = 0.
//  FSM states RUN, MEM_WAIT, REDIRECT; outputs decode combinationally from state+inputs (0-cycle latency).
//  Priority in RUN: jump > mem_busy > load-use.
//  RUN, jump_en_i=1, mem_busy_i=0:
//    pc_sel_o=1, redirect_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; stay RUN.
//  RUN, mem_busy_i=1: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=0; go MEM_WAIT.
//    If jump_en_i also =1: pend_vld<=1, pend_addr<=jump_addr_i.
//  RUN, load-use only (ex_is_load_i & ex_rd_i!=0 & ((rs1_used&rs1==rd)|(rs2_used&rs2==rd))):
//    hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 for exactly that cycle; stay RUN.
//    EX has advanced next cycle, so no repeat.
//  MEM_WAIT: hold_pc_o=hold_if_id_o=1, no flush.
//    jump_en_i with pend_vld=0 latches pend_addr, sets pend_vld.
//    jump_en_i with pend_vld=1 is ignored (oldest target kept; EX is frozen and re-presents it).
//    wait_cnt increments per cycle; wait_cnt==MAX_WAIT sets err_timeout_o (sticky until reset); pipe stays held.
//  MEM_WAIT, mem_busy_i=0: wait_cnt<=0.
//    pend_vld=1: go REDIRECT.
//    pend_vld=0: go RUN; the RUN rules apply that cycle.
//  REDIRECT (one cycle): pc_sel_o=1, redirect_addr_o=pend_addr, flush_if_id_o=flush_id_ex_o=1;
//    pend_vld<=0; go RUN. A mem_busy_i here goes MEM_WAIT after the redirect.
//  stall_cnt_o +1 each cycle hold_pc_o=1; holds at 2^CNT_W-1.
//  redirect_addr_o=0 when pc_sel_o=0.
// STRUCTURE
//  defines.v: `INST_NOP (32'h00000013), state encodings `PC_RUN/`PC_MEM_WAIT/`PC_REDIRECT.
//  Sub-module ld_use_detect (combinational rd/rs compare, outputs hazard bit); rest in pipe_ctrl.
//  State, pend_* and counters use dff_set with reset values above.
// TESTING
//  1 jump_en_i=1, addr=32'h0000_0100, no busy -> same cycle pc_sel_o=1, both flushes=1, redirect=0x100; next cycle all 0.
//  2 ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, rs2_used=1 -> one cycle hold_pc/hold_if_id/flush_id_ex=1.
//    Same case with ex_rd_i=0 -> no stall.
//  3 mem_busy_i high 3 cycles, jump_en_i=1 (0x200) in cycle 1, jump_en_i=1 (0x300) in cycle 2
//    -> holds 3 cycles, then 1-cycle REDIRECT to 0x200, stall_cnt_o=3.
//  4 jump_en_i and load-use in same cycle -> redirect only, flush_id_ex_o=1, hold_pc_o=0.
//  5 mem_busy_i held 256 cycles with MAX_WAIT=255 -> err_timeout_o rises, stays 1 after busy drops, until rst_n=0.
//  6 rst_n=0 asserted while in MEM_WAIT with pend_vld=1 -> next edge state RUN, pend cleared, no redirect after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants and state encodings for the pipeline
//                hazard/sequencing controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Bubble loaded into if_id on flush (addi x0, x0, 0)
    localparam logic [31:0] c_INST_NOP = 32'h0000_0013;

    localparam int          c_STATE_W     = 2;
    localparam logic [1:0]  c_PC_RUN      = 2'd0;
    localparam logic [1:0]  c_PC_MEM_WAIT = 2'd1;
    localparam logic [1:0]  c_PC_REDIRECT = 2'd2;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_ctrl_ld_use_detect.sv
// ============================================================================
//  Module      : ld_use_detect
//  Description : Combinational load-use hazard compare between the load in EX
//                and the source operands of the instruction in ID.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ld_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    output logic              o_hazard
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_rs1_hit    = i_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_rs2_used && (i_id_rs2 == i_ex_rd);
    assign o_hazard     = i_ex_is_load && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule : ld_use_detect

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hold/flush/redirect controller for the 5-stage core, with
//                stall-cycle counter and sticky memory-wait timeout flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              mem_busy_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              pc_sel_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              err_timeout_o
);

    import pipe_ctrl_pkg::*;

    localparam int                WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 r_pend_vld;
    logic [ADDR_W-1:0]    r_pend_addr;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 r_err_timeout;

    logic                 w_ld_use;
    logic                 w_run_rules;
    logic                 w_pend_set;

    ld_use_detect #(
        .REG_AW (REG_AW)
    ) u_ld_use_detect (
        .i_ex_is_load (ex_is_load_i),
        .i_ex_rd      (ex_rd_i),
        .i_id_rs1     (id_rs1_i),
        .i_id_rs2     (id_rs2_i),
        .i_rs1_used   (id_rs1_used_i),
        .i_rs2_used   (id_rs2_used_i),
        .o_hazard     (w_ld_use)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_PC_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_PC_RUN: begin
                w_state_nxt = mem_busy_i ? c_PC_MEM_WAIT : c_PC_RUN;
            end
            c_PC_MEM_WAIT: begin
                if (mem_busy_i) begin
                    w_state_nxt = c_PC_MEM_WAIT;
                end else if (r_pend_vld) begin
                    w_state_nxt = c_PC_REDIRECT;
                end else begin
                    w_state_nxt = c_PC_RUN;
                end
            end
            c_PC_REDIRECT: begin
                w_state_nxt = mem_busy_i ? c_PC_MEM_WAIT : c_PC_RUN;
            end
            default: begin
                w_state_nxt = c_PC_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output decode (same-cycle response to inputs)
    // ------------------------------------------------------------------
    always_comb begin
        hold_pc_o       = 1'b0;
        hold_if_id_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        pc_sel_o        = 1'b0;
        redirect_addr_o = '0;
        w_run_rules     = 1'b0;
        if (rst_n) begin
            case (r_state)
                c_PC_RUN: begin
                    w_run_rules = 1'b1;
                end
                c_PC_MEM_WAIT: begin
                    // With a pending target the release cycle is idle; REDIRECT follows
                    if (mem_busy_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                    end else begin
                        w_run_rules  = !r_pend_vld;
                    end
                end
                c_PC_REDIRECT: begin
                    pc_sel_o        = 1'b1;
                    redirect_addr_o = r_pend_addr;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                end
                default: begin
                    w_run_rules = 1'b0;
                end
            endcase

            if (w_run_rules) begin
                if (jump_en_i && !mem_busy_i) begin
                    pc_sel_o        = 1'b1;
                    redirect_addr_o = jump_addr_i;
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                end else if (mem_busy_i) begin
                    hold_pc_o       = 1'b1;
                    hold_if_id_o    = 1'b1;
                end else if (w_ld_use) begin
                    hold_pc_o       = 1'b1;
                    hold_if_id_o    = 1'b1;
                    flush_id_ex_o   = 1'b1;
                end
            end
        end
    end

    // Only the oldest redirect seen during a memory freeze is remembered
    assign w_pend_set = mem_busy_i && jump_en_i && !r_pend_vld &&
                        (r_state != c_PC_REDIRECT);

    // ------------------------------------------------------------------
    // Pending redirect, wait timer and performance counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_vld    <= 1'b0;
            r_pend_addr   <= '0;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == c_PC_REDIRECT) begin
                r_pend_vld  <= 1'b0;
            end else if (w_pend_set) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= jump_addr_i;
            end

            if (!mem_busy_i) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (mem_busy_i && (r_wait_cnt == c_WAIT_MAX)) begin
                r_err_timeout <= 1'b1;
            end

            if (hold_pc_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o   = r_stall_cnt;
    assign err_timeout_o = r_err_timeout;

endmodule : pipe_ctrl

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed plus randomized bench for pipe_ctrl against a
//                cycle-level behavioural model of the sequencing rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int ADDR_W   = 32;
    localparam int REG_AW   = 5;
    localparam int CNT_W    = 16;
    localparam int MAX_WAIT = 255;

    logic              clk;
    logic              rst_n;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic              mem_busy;
    logic              hold_pc;
    logic              hold_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              pc_sel;
    logic [ADDR_W-1:0] redirect_addr;
    logic [CNT_W-1:0]  stall_cnt;
    logic              err_timeout;

    int checks   = 0;
    int failures = 0;

    // Model: a memory freeze is "the previous cycle was busy"; targets seen
    // during a freeze sit in a one-deep queue until the release redirect.
    bit          m_known;
    bit          m_prev_busy;
    bit          m_redir_due;
    bit          m_timeout;
    int          m_consec;
    int          m_stall;
    logic [31:0] m_q[$];

    logic        e_hold, e_fif, e_fie, e_pcsel;
    logic [31:0] e_addr;

    pipe_ctrl #(
        .ADDR_W   (ADDR_W),
        .REG_AW   (REG_AW),
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_en_i       (jump_en),
        .jump_addr_i     (jump_addr),
        .ex_is_load_i    (ex_is_load),
        .ex_rd_i         (ex_rd),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_rs1_used_i   (rs1_used),
        .id_rs2_used_i   (rs2_used),
        .mem_busy_i      (mem_busy),
        .hold_pc_o       (hold_pc),
        .hold_if_id_o    (hold_if_id),
        .flush_if_id_o   (flush_if_id),
        .flush_id_ex_o   (flush_id_ex),
        .pc_sel_o        (pc_sel),
        .redirect_addr_o (redirect_addr),
        .stall_cnt_o     (stall_cnt),
        .err_timeout_o   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        jump_en    = 1'b0;
        jump_addr  = '0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
        id_rs1     = '0;
        id_rs2     = '0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        mem_busy   = 1'b0;
    endtask

    // Settle inputs, derive expected outputs from the rules, compare
    task automatic eval();
        bit ldu;
        #2;
        ldu = ex_is_load && (ex_rd != 0) &&
              ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
        e_hold = 0; e_fif = 0; e_fie = 0; e_pcsel = 0; e_addr = '0;
        if (rst_n) begin
            if (m_redir_due) begin
                e_pcsel = 1; e_addr = m_q[0]; e_fif = 1; e_fie = 1;
            end else if (m_prev_busy && mem_busy) begin
                e_hold = 1;
            end else if (m_prev_busy && m_q.size() > 0) begin
                e_hold = 0;
            end else if (jump_en && !mem_busy) begin
                e_pcsel = 1; e_addr = jump_addr; e_fif = 1; e_fie = 1;
            end else if (mem_busy) begin
                e_hold = 1;
            end else if (ldu) begin
                e_hold = 1; e_fie = 1;
            end
        end
        chk("hold_pc",       {31'd0, hold_pc},     {31'd0, e_hold});
        chk("hold_if_id",    {31'd0, hold_if_id},  {31'd0, e_hold});
        chk("flush_if_id",   {31'd0, flush_if_id}, {31'd0, e_fif});
        chk("flush_id_ex",   {31'd0, flush_id_ex}, {31'd0, e_fie});
        chk("pc_sel",        {31'd0, pc_sel},      {31'd0, e_pcsel});
        chk("redirect_addr", redirect_addr,        e_addr);
        if (m_known) begin
            chk("stall_cnt",   {16'd0, stall_cnt},   m_stall);
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_timeout});
        end
    endtask

    task automatic adv();
        bit nr;
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1; m_prev_busy = 0; m_redir_due = 0; m_timeout = 0;
            m_consec = 0; m_stall = 0; m_q.delete();
        end else begin
            nr = !m_redir_due && m_prev_busy && !mem_busy && m_q.size() > 0;
            if (m_redir_due) m_q.delete(0);
            else if (mem_busy && jump_en && m_q.size() == 0) m_q.push_back(jump_addr);
            if (mem_busy && m_consec >= MAX_WAIT) m_timeout = 1;
            m_consec = mem_busy ? m_consec + 1 : 0;
            if (e_hold && m_stall < 65535) m_stall++;
            m_prev_busy = mem_busy;
            m_redir_due = nr;
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        set_idle();
        m_known = 0;
        rst_n   = 1'b0;

        // Reset values
        do_reset();
        eval();
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_err",   {31'd0, err_timeout}, 32'd0);
        adv();

        // 1: plain redirect
        jump_en = 1; jump_addr = 32'h0000_0100;
        eval();
        chk("t1_pc_sel", {31'd0, pc_sel}, 32'd1);
        chk("t1_addr", redirect_addr, 32'h100);
        chk("t1_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        adv();
        set_idle();
        eval();
        chk("t1_after", {28'd0, pc_sel, flush_if_id, flush_id_ex, hold_pc}, 32'd0);
        adv();

        // 2: load-use, then same with rd = x0
        do_reset();
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; rs2_used = 1;
        eval();
        chk("t2_stall", {29'd0, hold_pc, hold_if_id, flush_id_ex}, 32'd7);
        adv();
        set_idle();
        eval();
        chk("t2_once", {31'd0, hold_pc}, 32'd0);
        adv();
        ex_is_load = 1; ex_rd = 0; id_rs2 = 0; rs2_used = 1;
        eval();
        chk("t2_x0", {31'd0, hold_pc}, 32'd0);
        adv();

        // 3: busy x3 with two jumps, oldest wins
        do_reset();
        mem_busy = 1; jump_en = 1; jump_addr = 32'h200; step();
        jump_addr = 32'h300; step();
        jump_en = 0; step();
        mem_busy = 0;
        eval();
        chk("t3_release", {31'd0, hold_pc}, 32'd0);
        adv();
        eval();
        chk("t3_pc_sel", {31'd0, pc_sel}, 32'd1);
        chk("t3_addr", redirect_addr, 32'h200);
        chk("t3_stall", {16'd0, stall_cnt}, 32'd3);
        adv();
        eval();
        chk("t3_done", {31'd0, pc_sel}, 32'd0);
        adv();

        // 4: jump and load-use together
        do_reset();
        jump_en = 1; jump_addr = 32'h0000_0abc;
        ex_is_load = 1; ex_rd = 7; id_rs1 = 7; rs1_used = 1;
        eval();
        chk("t4_pc_sel", {31'd0, pc_sel}, 32'd1);
        chk("t4_fie", {31'd0, flush_id_ex}, 32'd1);
        chk("t4_hold", {31'd0, hold_pc}, 32'd0);
        adv();

        // 5: timeout after 256 busy cycles
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 256; i++) begin
            eval();
            if (i == 255) chk("t5_not_yet", {31'd0, err_timeout}, 32'd0);
            adv();
        end
        mem_busy = 0;
        eval();
        chk("t5_err", {31'd0, err_timeout}, 32'd1);
        adv();
        for (int i = 0; i < 3; i++) step();
        eval();
        chk("t5_sticky", {31'd0, err_timeout}, 32'd1);
        adv();
        do_reset();
        eval();
        chk("t5_cleared", {31'd0, err_timeout}, 32'd0);
        adv();

        // 6: reset during MEM_WAIT with a pending target
        mem_busy = 1; jump_en = 1; jump_addr = 32'h400; step();
        jump_en = 0; step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t6_no_redir", {31'd0, pc_sel}, 32'd0);
            adv();
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            mem_busy   = ($urandom_range(0, 9) < 3);
            jump_en    = ($urandom_range(0, 9) < 2);
            jump_addr  = $urandom();
            ex_is_load = $urandom_range(0, 1);
            ex_rd      = REG_AW'($urandom_range(0, 3));
            id_rs1     = REG_AW'($urandom_range(0, 3));
            id_rs2     = REG_AW'($urandom_range(0, 3));
            rs1_used   = $urandom_range(0, 1);
            rs2_used   = $urandom_range(0, 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_ctrl

`default_nettype wire
